// File: rtl/vec_sum_sched_if.sv
// Requester-side handshake plus engine-side data/sum wiring for vec_sum_sched.
// The slave modport is the scheduler; the master modport is the requesters and engine.
interface vec_sum_sched_if #(
    parameter int DATA_W = 16,
    parameter int POS_W  = 4,
    parameter int N_REQ  = 4
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        resp_valid;
    logic [POS_W-1:0]        resp_sum;
    logic                    busy;
    logic [DATA_W-1:0]       eng_data;
    logic                    eng_reset;
    logic [POS_W-1:0]        eng_sum;

    modport slave (
        input  req_valid, req_data, eng_sum,
        output req_ready, resp_valid, resp_sum, busy, eng_data, eng_reset
    );

    modport master (
        output req_valid, req_data, eng_sum,
        input  req_ready, resp_valid, resp_sum, busy, eng_data, eng_reset
    );
endinterface

// File: rtl/vec_sum_sched.sv
// Round-robin scheduler sharing one vec_sum engine between N_REQ requesters.
// One job at a time: accept, hold engine in reset for a load cycle, run CALC_CYC cycles, return sum.
module vec_sum_sched #(
    parameter int DATA_W   = 16,
    parameter int POS_W    = 4,
    parameter int N_REQ    = 4,
    parameter int CALC_CYC = 3
) (
    input  logic           clock,
    input  logic           reset,
    vec_sum_sched_if.slave bus
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(CALC_CYC) + 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_RESP} state_t;

    state_t              r_state, w_state_nxt;
    logic [IDX_W-1:0]    r_ptr, r_gnt, w_gnt, w_cand;
    logic                w_found;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_eng_data, w_sel_data;
    logic                r_eng_reset, r_busy;
    logic [N_REQ-1:0]    r_resp_valid, w_ready;
    logic [POS_W-1:0]    r_resp_sum;

    // Walk from farthest to nearest after the pointer so the nearest valid requester wins.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = r_ptr;
        w_cand  = r_ptr;
        for (int k = N_REQ; k >= 1; k--) begin
            w_cand = IDX_W'((int'(r_ptr) + k) % N_REQ);
            if (bus.req_valid[w_cand]) begin
                w_found = 1'b1;
                w_gnt   = w_cand;
            end
        end
    end

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt == IDX_W'(i)) w_sel_data = bus.req_data[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        w_ready = '0;
        if (reset && r_state == S_IDLE && w_found) w_ready = N_REQ'(1) << w_gnt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_RUN;
            S_RUN:   if (r_cnt == '0) w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_ptr        <= IDX_W'(N_REQ - 1);
            r_gnt        <= '0;
            r_cnt        <= '0;
            r_eng_data   <= '0;
            r_eng_reset  <= 1'b1;
            r_resp_valid <= '0;
            r_resp_sum   <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_busy       <= (w_state_nxt != S_IDLE);
            // Engine only leaves reset for the RUN window.
            r_eng_reset  <= (w_state_nxt != S_RUN);
            r_resp_valid <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_eng_data <= w_sel_data;
                        r_gnt      <= w_gnt;
                        r_ptr      <= w_gnt;
                    end
                end
                S_LOAD: r_cnt <= CNT_W'(CALC_CYC - 1);
                S_RUN: begin
                    if (r_cnt == '0) begin
                        r_resp_sum   <= bus.eng_sum;
                        r_resp_valid <= N_REQ'(1) << r_gnt;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready  = w_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_sum   = r_resp_sum;
    assign bus.busy       = r_busy;
    assign bus.eng_data   = r_eng_data;
    assign bus.eng_reset  = r_eng_reset;
endmodule

// File: tb/tb_vec_sum_sched.sv
// Self-checking bench for vec_sum_sched: popcount engine model, rotation model, random jobs.
module tb_vec_sum_sched;
    localparam int DATA_W = 16, POS_W = 4, N_REQ = 4, CALC_CYC = 3;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   total = 0, bad = 0, cyc = 0;
    int   m_last = N_REQ - 1;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    vec_sum_sched_if #(.DATA_W(DATA_W), .POS_W(POS_W), .N_REQ(N_REQ)) bus ();
    vec_sum_sched_if #(.DATA_W(DATA_W), .POS_W(POS_W), .N_REQ(N_REQ)) bus1 ();

    vec_sum_sched #(.DATA_W(DATA_W), .POS_W(POS_W), .N_REQ(N_REQ), .CALC_CYC(CALC_CYC))
        u_dut (.clock(clock), .reset(reset), .bus(bus));
    vec_sum_sched #(.DATA_W(DATA_W), .POS_W(POS_W), .N_REQ(N_REQ), .CALC_CYC(1))
        u_dut1 (.clock(clock), .reset(reset), .bus(bus1));

    // Engine models: registered popcount, forced to zero while held in reset.
    logic [POS_W-1:0] pop0 = '0, pop1 = '0;
    always @(posedge clock) begin
        pop0 <= POS_W'($countones(bus.eng_data));
        pop1 <= POS_W'($countones(bus1.eng_data));
    end
    assign bus.eng_sum  = bus.eng_reset  ? '0 : pop0;
    assign bus1.eng_sum = bus1.eng_reset ? '0 : pop1;

    logic [DATA_W-1:0] mdata [N_REQ];

    function automatic int model_grant(logic [N_REQ-1:0] v, int last);
        int q[$];
        for (int k = 1; k <= N_REQ; k++) q.push_back((last + k) % N_REQ);
        foreach (q[j]) if (v[q[j]]) return q[j];
        return -1;
    endfunction

    function automatic logic [POS_W-1:0] model_sum(logic [DATA_W-1:0] d);
        int c = 0;
        for (int i = 0; i < DATA_W; i++) c += int'(d[i]);
        return POS_W'(c % (1 << POS_W));
    endfunction

    task automatic set_req(input int i, input logic [DATA_W-1:0] d);
        bus.req_data[i*DATA_W +: DATA_W] = d;
        bus.req_valid[i] = 1'b1;
        mdata[i] = d;
    endtask

    // Waits for a handshake, then observes the whole job; caller must be just after a negedge.
    task automatic run_one(input bit drop, output bit ok, output int gidx,
                           output logic [N_REQ-1:0] hs, output int t0, output int lat,
                           output logic [N_REQ-1:0] rv, output logic [POS_W-1:0] sum,
                           output int rst_lo, output int busy_n, output logic [DATA_W-1:0] edata);
        ok = 0; gidx = 0; hs = '0; t0 = 0; lat = -1; rv = '0; sum = '0;
        rst_lo = 0; busy_n = 0; edata = '0;
        for (int n = 0; n < 40; n++) begin
            #1;
            if ((bus.req_valid & bus.req_ready) != '0) begin
                hs = bus.req_ready; ok = 1; break;
            end
            @(negedge clock);
        end
        if (!ok) return;
        t0 = cyc;
        for (int i = N_REQ - 1; i >= 0; i--) if (hs[i]) gidx = i;
        @(posedge clock); #1;
        if (drop) bus.req_valid[gidx] = 1'b0;
        ok = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clock); #1;
            if (bus.busy) begin
                busy_n++;
                if (busy_n == 1) edata = bus.eng_data;
            end
            if (!bus.eng_reset) rst_lo++;
            if (bus.resp_valid != '0 && lat < 0) begin
                lat = cyc - t0; rv = bus.resp_valid; sum = bus.resp_sum;
            end
            if (!bus.busy && lat >= 0) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < N_REQ; i++) set_req(i, DATA_W'($urandom));
        bus1.req_valid = '1;
        @(negedge clock); @(negedge clock); #1;
        total++; if (bus.req_ready !== '0) begin bad++; $display("FAIL rst_ready: got %b want 0", bus.req_ready); end
        total++; if (bus.eng_reset !== 1'b1) begin bad++; $display("FAIL rst_eng_reset: got %b want 1", bus.eng_reset); end
        total++; if (bus.eng_data !== '0) begin bad++; $display("FAIL rst_eng_data: got %h want 0", bus.eng_data); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        total++; if (bus.resp_valid !== '0 || bus.resp_sum !== '0) begin bad++;
            $display("FAIL rst_resp: got %b/%h want 0/0", bus.resp_valid, bus.resp_sum); end
        total++; if (bus1.req_ready !== '0 || bus1.eng_reset !== 1'b1) begin bad++;
            $display("FAIL rst_dut1: got ready=%b eng_reset=%b want 0/1", bus1.req_ready, bus1.eng_reset); end
        bus.req_valid = '0; bus1.req_valid = '0;
        reset = 1'b1;
        m_last = N_REQ - 1;
        @(negedge clock);
    endtask

    task automatic test_all_four();
        logic [DATA_W-1:0] d [4] = '{16'b0010101111010111, 16'b1110101010001110, 16'b1001101010100011, 16'h0000};
        bit ok; int g, t0, lat, rl, bn, prev_t0, exp; logic [N_REQ-1:0] hs, rv; logic [POS_W-1:0] s; logic [DATA_W-1:0] ed;
        prev_t0 = 0;
        for (int i = 0; i < 4; i++) set_req(i, d[i]);
        for (int j = 0; j < 4; j++) begin
            exp = model_grant(bus.req_valid, m_last);
            run_one(1, ok, g, hs, t0, lat, rv, s, rl, bn, ed);
            total++; if (!ok) begin bad++; $display("FAIL all4_timeout job%0d: got no completion want completion", j); end
            total++; if (g != exp) begin bad++; $display("FAIL all4_grant job%0d: got %0d want %0d", j, g, exp); end
            total++; if (s !== model_sum(mdata[exp])) begin bad++;
                $display("FAIL all4_sum job%0d: got %0d want %0d", j, s, model_sum(mdata[exp])); end
            total++; if (rv !== N_REQ'(1) << exp) begin bad++; $display("FAIL all4_resp_valid job%0d: got %b want one-hot %0d", j, rv, exp); end
            if (j > 0) begin
                total++; if (t0 - prev_t0 != CALC_CYC + 3) begin bad++;
                    $display("FAIL all4_spacing job%0d: got %0d want %0d", j, t0 - prev_t0, CALC_CYC + 3); end
            end
            prev_t0 = t0;
            m_last = exp;
        end
    endtask

    task automatic test_single();
        bit ok; int g, t0, lat, rl, bn; logic [N_REQ-1:0] hs, rv; logic [POS_W-1:0] s; logic [DATA_W-1:0] ed;
        set_req(0, 16'b1001101010100011);
        run_one(1, ok, g, hs, t0, lat, rv, s, rl, bn, ed);
        total++; if (!ok) begin bad++; $display("FAIL single_timeout: got no completion want completion"); end
        total++; if (hs !== 4'b0001) begin bad++; $display("FAIL single_ready: got %b want 0001", hs); end
        total++; if (rl != CALC_CYC) begin bad++; $display("FAIL single_eng_reset_low: got %0d want %0d", rl, CALC_CYC); end
        total++; if (lat != CALC_CYC + 2) begin bad++; $display("FAIL single_latency: got %0d want %0d", lat, CALC_CYC + 2); end
        total++; if (rv !== 4'b0001) begin bad++; $display("FAIL single_resp_valid: got %b want 0001", rv); end
        total++; if (s !== model_sum(mdata[0])) begin bad++; $display("FAIL single_sum: got %0d want %0d", s, model_sum(mdata[0])); end
        total++; if (bn != CALC_CYC + 2) begin bad++; $display("FAIL single_busy_len: got %0d want %0d", bn, CALC_CYC + 2); end
        total++; if (ed !== mdata[0]) begin bad++; $display("FAIL single_eng_data: got %h want %h", ed, mdata[0]); end
        total++; if (bus.resp_sum !== model_sum(mdata[0]) || bus.resp_valid !== '0) begin bad++;
            $display("FAIL single_hold: got %0d/%b want %0d/0", bus.resp_sum, bus.resp_valid, model_sum(mdata[0])); end
        m_last = 0;
    endtask

    task automatic test_fairness();
        bit ok; int g, t0, lat, rl, bn, exp, prev; logic [N_REQ-1:0] hs, rv; logic [POS_W-1:0] s; logic [DATA_W-1:0] ed;
        prev = -1;
        set_req(1, DATA_W'($urandom)); set_req(3, DATA_W'($urandom));
        for (int j = 0; j < 4; j++) begin
            exp = model_grant(bus.req_valid, m_last);
            run_one(0, ok, g, hs, t0, lat, rv, s, rl, bn, ed);
            total++; if (!ok || g != exp) begin bad++; $display("FAIL fair_grant job%0d: got %0d want %0d", j, g, exp); end
            total++; if (g == prev) begin bad++; $display("FAIL fair_repeat job%0d: got %0d twice want alternation", j, g); end
            total++; if (s !== model_sum(mdata[exp])) begin bad++;
                $display("FAIL fair_sum job%0d: got %0d want %0d", j, s, model_sum(mdata[exp])); end
            prev = g; m_last = exp;
        end
        bus.req_valid = '0;
    endtask

    task automatic test_reset_mid_run();
        bit ok; int g, t0, lat, rl, bn, exp; logic [N_REQ-1:0] hs, rv; logic [POS_W-1:0] s; logic [DATA_W-1:0] ed;
        ok = 0;
        set_req(2, DATA_W'($urandom));
        for (int n = 0; n < 40; n++) begin
            #1;
            if (bus.req_valid[2] && bus.req_ready[2]) begin ok = 1; break; end
            @(negedge clock);
        end
        total++; if (!ok) begin bad++; $display("FAIL midrst_accept: got no accept want accept of req 2"); end
        @(posedge clock); #1; bus.req_valid[2] = 1'b0;
        @(negedge clock); @(negedge clock); #1;
        total++; if (bus.eng_reset !== 1'b0) begin bad++; $display("FAIL midrst_in_run: got eng_reset=%b want 0", bus.eng_reset); end
        reset = 1'b0;
        for (int i = 0; i < N_REQ; i++) set_req(i, DATA_W'($urandom));
        @(negedge clock); #1;
        total++; if (bus.eng_reset !== 1'b1 || bus.busy !== 1'b0 || bus.resp_valid !== '0) begin bad++;
            $display("FAIL midrst_abort: got eng_reset=%b busy=%b resp=%b want 1/0/0", bus.eng_reset, bus.busy, bus.resp_valid); end
        total++; if (bus.req_ready !== '0) begin bad++; $display("FAIL midrst_ready: got %b want 0", bus.req_ready); end
        reset = 1'b1;
        m_last = N_REQ - 1;
        exp = model_grant(bus.req_valid, m_last);
        run_one(1, ok, g, hs, t0, lat, rv, s, rl, bn, ed);
        total++; if (!ok || g != exp) begin bad++; $display("FAIL midrst_regrant: got %0d want %0d", g, exp); end
        total++; if (lat != CALC_CYC + 2 || s !== model_sum(mdata[exp])) begin bad++;
            $display("FAIL midrst_job: got lat=%0d sum=%0d want %0d/%0d", lat, s, CALC_CYC + 2, model_sum(mdata[exp])); end
        m_last = exp;
        bus.req_valid = '0;
    endtask

    task automatic test_hold_withdraw();
        bit ok; int g, t0, lat, rl, bn, exp, run_n, viol; logic [N_REQ-1:0] hs, rv; logic [POS_W-1:0] s; logic [DATA_W-1:0] ed;
        ok = 0; run_n = 0; viol = 0; lat = -1; s = '0; rv = '0; t0 = 0;
        set_req(0, DATA_W'($urandom));
        for (int n = 0; n < 40; n++) begin
            #1;
            if (bus.req_valid[0] && bus.req_ready[0]) begin ok = 1; break; end
            @(negedge clock);
        end
        t0 = cyc;
        total++; if (!ok) begin bad++; $display("FAIL hold_accept0: got no accept want accept of req 0"); end
        @(posedge clock); #1; bus.req_valid[0] = 1'b0;
        ok = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clock); #1;
            if (bus.busy && bus.req_ready != '0) viol++;
            if (!bus.eng_reset) begin
                if (run_n == 0) begin
                    set_req(1, DATA_W'($urandom)); set_req(2, DATA_W'($urandom));
                end else begin
                    bus.req_valid[2] = 1'b0;
                end
                run_n++;
            end
            if (bus.resp_valid != '0 && lat < 0) begin lat = cyc - t0; rv = bus.resp_valid; s = bus.resp_sum; end
            if (!bus.busy && lat >= 0) begin ok = 1; break; end
        end
        total++; if (viol != 0) begin bad++; $display("FAIL hold_ready_busy: got %0d ready cycles want 0", viol); end
        total++; if (!ok || lat != CALC_CYC + 2 || rv !== 4'b0001 || s !== model_sum(mdata[0])) begin bad++;
            $display("FAIL hold_job0: got lat=%0d rv=%b sum=%0d want %0d/0001/%0d", lat, rv, s, CALC_CYC + 2, model_sum(mdata[0])); end
        m_last = 0;
        exp = model_grant(bus.req_valid, m_last);
        #1;
        total++; if (bus.req_ready !== N_REQ'(1) << exp) begin bad++;
            $display("FAIL hold_ready_idle: got %b want one-hot %0d", bus.req_ready, exp); end
        run_one(1, ok, g, hs, t0, lat, rv, s, rl, bn, ed);
        total++; if (!ok || g != exp || s !== model_sum(mdata[exp])) begin bad++;
            $display("FAIL hold_job1: got grant=%0d sum=%0d want %0d/%0d", g, s, exp, model_sum(mdata[exp])); end
        m_last = exp;
        viol = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clock); #1;
            if (bus.busy) viol++;
        end
        total++; if (viol != 0) begin bad++; $display("FAIL withdraw_ignored: got %0d busy cycles want 0", viol); end
    endtask

    task automatic test_random();
        bit ok; int g, t0, lat, rl, bn, exp; logic [N_REQ-1:0] hs, rv; logic [POS_W-1:0] s; logic [DATA_W-1:0] ed;
        for (int j = 0; j < 12; j++) begin
            for (int i = 0; i < N_REQ; i++)
                if (!bus.req_valid[i] && $urandom_range(0, 1) == 1) set_req(i, DATA_W'($urandom));
            if (bus.req_valid == '0) set_req($urandom_range(0, N_REQ - 1), DATA_W'($urandom));
            exp = model_grant(bus.req_valid, m_last);
            run_one(1, ok, g, hs, t0, lat, rv, s, rl, bn, ed);
            total++; if (!ok || g != exp) begin bad++; $display("FAIL rand_grant job%0d: got %0d want %0d", j, g, exp); end
            total++; if (s !== model_sum(mdata[exp]) || lat != CALC_CYC + 2) begin bad++;
                $display("FAIL rand_result job%0d: got sum=%0d lat=%0d want %0d/%0d", j, s, lat, model_sum(mdata[exp]), CALC_CYC + 2); end
            m_last = exp;
        end
        bus.req_valid = '0;
    endtask

    task automatic test_calc1();
        bit ok; int t0, lat, rl; logic [N_REQ-1:0] rv; logic [POS_W-1:0] s; logic [DATA_W-1:0] d;
        ok = 0; lat = -1; rl = 0; rv = '0; s = '0; t0 = 0;
        d = 16'b1110101010001110;
        bus1.req_data[DATA_W-1:0] = d; bus1.req_valid = 4'b0001;
        for (int n = 0; n < 40; n++) begin
            #1;
            if (bus1.req_ready[0]) begin ok = 1; break; end
            @(negedge clock);
        end
        t0 = cyc;
        total++; if (!ok) begin bad++; $display("FAIL calc1_accept: got no accept want accept"); end
        @(posedge clock); #1; bus1.req_valid = '0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clock); #1;
            if (!bus1.eng_reset) rl++;
            if (bus1.resp_valid != '0 && lat < 0) begin lat = cyc - t0; rv = bus1.resp_valid; s = bus1.resp_sum; end
        end
        total++; if (lat != 3) begin bad++; $display("FAIL calc1_latency: got %0d want 3", lat); end
        total++; if (s !== model_sum(d) || rv !== 4'b0001) begin bad++;
            $display("FAIL calc1_result: got sum=%0d rv=%b want %0d/0001", s, rv, model_sum(d)); end
        total++; if (rl != 1) begin bad++; $display("FAIL calc1_eng_reset_low: got %0d want 1", rl); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = '0; bus.req_data = '0;
        bus1.req_valid = '0; bus1.req_data = '0;
        test_reset();
        test_all_four();
        test_single();
        test_fairness();
        test_reset_mid_run();
        test_hold_withdraw();
        test_random();
        test_calc1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vec_sum_sched.md
Name: vec_sum_sched

Overview:
- Round-robin scheduler that shares one vec_sum engine between N_REQ requesters.
- Accepts one data word from the winning requester and drives it onto the engine.
- Sequences the engine's active-high reset to start the job, waits a fixed compute time, captures the engine's sum and returns it to the granted requester with a one-cycle response pulse.
- Sits between requester blocks and a single vec_sum instance.

Parameters:
DATA_W, 16, width of each data word (matches vec_sum DATA_W)
POS_W, 4, width of the sum result (matches vec_sum POS_W)
N_REQ, 4, number of requesters, >=2
CALC_CYC, 3, cycles the engine needs out of reset before its sum is valid, >=1

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
req_valid  input  N_REQ  per-requester request strobe, held until accepted
req_data  input  N_REQ*DATA_W  requester i data at bits [i*DATA_W +: DATA_W]
req_ready  output  N_REQ  one-hot accept; handshake = req_valid[i] & req_ready[i]
resp_valid  output  N_REQ  one-hot, one-cycle result pulse to the granted requester
resp_sum  output  POS_W  result, valid while resp_valid nonzero
busy  output  1  high in LOAD, RUN, RESP
eng_data  output  DATA_W  data to the engine's data port
eng_reset  output  1  to the engine's reset (active-high)
eng_sum  input  POS_W  from the engine's sum port

Behaviour:
- Reset (reset=0 at an edge):
  - state=IDLE, eng_reset=1, eng_data=0, resp_valid=0, resp_sum=0, busy=0.
  - Round-robin pointer=N_REQ-1, so requester 0 has highest priority first.
  - req_ready is forced to 0 while reset=0.
- States: IDLE, LOAD, RUN, RESP. All outputs are registered except req_ready.
- IDLE:
  - eng_reset=1 (engine parked in reset).
  - Grant = first i with req_valid[i]=1, searching ptr+1, ptr+2, ... mod N_REQ.
  - req_ready = one-hot(grant), combinational.
  - On accept: latch req_data slice into eng_data, latch grant index, ptr<=grant, go to LOAD.
  - No valid request: stay in IDLE, req_ready=0.
- LOAD (1 cycle): eng_reset=1, eng_data stable. Next: RUN, with cnt=CALC_CYC-1.
- RUN:
  - eng_reset=0, eng_data stable, cnt decrements each cycle.
  - When cnt=0: resp_sum<=eng_sum (sampled that edge), resp_valid<=one-hot(grant), go to RESP.
- RESP (1 cycle):
  - resp_valid one-hot to the grantee, resp_sum holds.
  - eng_reset<=1.
  - Next: IDLE, with resp_valid<=0 on exit.
  - resp_sum holds until the next capture.
- Latency: accept in cycle t → LOAD t+1 → RUN t+2..t+1+CALC_CYC → resp_valid in cycle t+2+CALC_CYC. With CALC_CYC=3, resp_valid is in t+5.
- Throughput: one job per CALC_CYC+3 cycles. The earliest next accept is the IDLE cycle after RESP.
- req_ready is 0 in LOAD/RUN/RESP. Requests arriving while busy wait; requesters must hold req_valid and req_data.
- A requester dropping req_valid before acceptance has no effect and is not recorded.
- Simultaneous requests: exactly one grant per IDLE cycle, by rotation. A requester just served has lowest priority next time.
- Reset mid-operation (any state): job aborted, no resp_valid, all values go to reset state, eng_reset=1 on the next cycle.
- cnt width = clog2(CALC_CYC)+1; cnt never wraps.

Test Plan:
Bench engine model: eng_sum registered each edge; value is 0 while eng_reset=1, otherwise popcount(eng_data) truncated to POS_W. Defaults apply.
1. Single request: req_valid[0]=1, data 16'b1001101010100011 → req_ready=4'b0001 that cycle; eng_reset low for exactly 3 cycles; resp_valid=4'b0001 five cycles after accept; resp_sum=8; busy high for 5 cycles.
2. All four requesting at once (data 16'b0010101111010111, 16'b1110101010001110, 16'b1001101010100011, 0) → grant order 0,1,2,3; resp_sum 10, 9, 8, 0; next accept always on the IDLE cycle after RESP (6-cycle spacing).
3. Fairness: requesters 1 and 3 hold req_valid continuously → grants alternate 1,3,1,3; neither is served twice in a row.
4. Reset mid-RUN: assert reset=0 for one cycle during RUN of a req 2 job → no resp_valid; eng_reset=1 and busy=0 after the edge; next grant with all requesting goes to requester 0.
5. Hold and withdraw: req 1 raises valid during RUN of a req 0 job → req_ready[1] stays 0 until IDLE, then it is accepted. Req 2 pulses valid only during RUN → never granted.
6. CALC_CYC=1 rebuild: single request 16'b1110101010001110 → resp_valid three cycles after accept, resp_sum=9.
